// File: rtl/multi_core_hash_dispatcher_if.sv
// Controller-side and core-side signal bundle for the multi-core hash dispatcher.
// The dispatcher connects through the slave modport; the controller and core array use master.
interface multi_core_hash_dispatcher_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int RESULT_W  = 288,
    parameter int ID_W      = 2
);
    logic                          begin_hash;
    logic                          quit_hash;
    logic [NONCE_W-1:0]            nonce_base;
    logic [NUM_CORES-1:0]          core_begin;
    logic [NUM_CORES-1:0]          core_quit;
    logic [NUM_CORES*NONCE_W-1:0]  core_nonce_start;
    logic [NONCE_W-1:0]            core_nonce_stride;
    logic [NUM_CORES-1:0]          core_done;
    logic [NUM_CORES-1:0]          core_valid;
    logic [NUM_CORES*RESULT_W-1:0] core_hash;
    logic                          hash_done;
    logic                          valid_hash_flag;
    logic [RESULT_W-1:0]           valid_hash;
    logic [ID_W-1:0]               winner_id;
    logic                          busy;

    modport slave (
        input  begin_hash, quit_hash, nonce_base, core_done, core_valid, core_hash,
        output core_begin, core_quit, core_nonce_start, core_nonce_stride,
               hash_done, valid_hash_flag, valid_hash, winner_id, busy
    );

    modport master (
        output begin_hash, quit_hash, nonce_base, core_done, core_valid, core_hash,
        input  core_begin, core_quit, core_nonce_start, core_nonce_stride,
               hash_done, valid_hash_flag, valid_hash, winner_id, busy
    );
endinterface

// File: rtl/multi_core_hash_dispatcher.sv
// Fans one nonce search out over NUM_CORES interleaved hash cores and reports the
// lowest-index winning result with the same done/flag/hash view a single core gives.
//
// state  | meaning
// IDLE   | waiting for begin_hash; results from the last search held
// LAUNCH | core_begin pulsed to every core, start nonces presented
// RUN    | collecting core_done; watching for win, exhaustion or quit
// QUIT   | core_quit pulsed to cores that have not finished
// REPORT | hash_done pulsed to the controller
// ABORT  | controller quit: core_quit to unfinished cores, no hash_done
module multi_core_hash_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int RESULT_W  = 288,
    parameter int ID_W      = 2
) (
    input logic clk,
    input logic n_rst,
    multi_core_hash_dispatcher_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_QUIT, S_REPORT, S_ABORT
    } state_t;

    state_t                       state_q, state_d;
    logic [NUM_CORES-1:0]         core_begin_q, core_begin_d;
    logic [NUM_CORES-1:0]         core_quit_q, core_quit_d;
    logic [NUM_CORES*NONCE_W-1:0] nonce_start_q, nonce_start_d;
    logic [NUM_CORES-1:0]         done_mask_q, done_mask_d;
    logic                         hash_done_q, hash_done_d;
    logic                         flag_q, flag_d;
    logic [RESULT_W-1:0]          hash_q, hash_d;
    logic [ID_W-1:0]              win_id_q, win_id_d;
    logic                         busy_q, busy_d;

    logic [NUM_CORES-1:0]         hit;
    logic [NUM_CORES-1:0]         seen;
    logic [ID_W-1:0]              hit_id;
    logic [RESULT_W-1:0]          hit_hash;

    assign hit  = bus.core_done & bus.core_valid;
    assign seen = done_mask_q | bus.core_done;

    // Descending scan so the lowest simultaneous winner is the one left standing.
    always_comb begin
        hit_id   = '0;
        hit_hash = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_id   = ID_W'(i);
                hit_hash = bus.core_hash[i*RESULT_W +: RESULT_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        core_begin_d  = '0;
        core_quit_d   = '0;
        hash_done_d   = 1'b0;
        nonce_start_d = nonce_start_q;
        done_mask_d   = done_mask_q;
        flag_d        = flag_q;
        hash_d        = hash_q;
        win_id_d      = win_id_q;
        // Outputs are registered from the next state, so each pulse is computed
        // on the transition into the state where it must be visible.
        unique case (state_q)
            S_IDLE: begin
                if (bus.begin_hash) begin
                    state_d      = S_LAUNCH;
                    done_mask_d  = '0;
                    flag_d       = 1'b0;
                    core_begin_d = '1;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        nonce_start_d[i*NONCE_W +: NONCE_W] = bus.nonce_base + NONCE_W'(i);
                    end
                end
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                done_mask_d = seen;
                if (bus.quit_hash) begin
                    state_d     = S_ABORT;
                    core_quit_d = ~seen;
                    flag_d      = 1'b0;
                end else if (|hit) begin
                    state_d     = S_QUIT;
                    core_quit_d = ~seen;
                    flag_d      = 1'b1;
                    hash_d      = hit_hash;
                    win_id_d    = hit_id;
                end else if (&seen) begin
                    state_d     = S_REPORT;
                    hash_done_d = 1'b1;
                    flag_d      = 1'b0;
                end
            end
            S_QUIT: begin
                state_d     = S_REPORT;
                hash_done_d = 1'b1;
            end
            S_REPORT: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q       <= S_IDLE;
            core_begin_q  <= '0;
            core_quit_q   <= '0;
            nonce_start_q <= '0;
            done_mask_q   <= '0;
            hash_done_q   <= 1'b0;
            flag_q        <= 1'b0;
            hash_q        <= '0;
            win_id_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_begin_q  <= core_begin_d;
            core_quit_q   <= core_quit_d;
            nonce_start_q <= nonce_start_d;
            done_mask_q   <= done_mask_d;
            hash_done_q   <= hash_done_d;
            flag_q        <= flag_d;
            hash_q        <= hash_d;
            win_id_q      <= win_id_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.core_begin        = core_begin_q;
    assign bus.core_quit         = core_quit_q;
    assign bus.core_nonce_start  = nonce_start_q;
    assign bus.core_nonce_stride = NONCE_W'(NUM_CORES);
    assign bus.hash_done         = hash_done_q;
    assign bus.valid_hash_flag   = flag_q;
    assign bus.valid_hash        = hash_q;
    assign bus.winner_id         = win_id_q;
    assign bus.busy              = busy_q;
endmodule

// File: tb/tb_multi_core_hash_dispatcher.sv
// Directed and randomized searches for the hash dispatcher, scored against a
// per-search outcome model built from each core's finish cycle and validity.
module tb_multi_core_hash_dispatcher;
    localparam int NC = 4;
    localparam int NW = 32;
    localparam int RW = 288;
    localparam int IW = 2;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    multi_core_hash_dispatcher_if #(.NUM_CORES(NC), .NONCE_W(NW), .RESULT_W(RW), .ID_W(IW)) bus ();

    multi_core_hash_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW), .RESULT_W(RW), .ID_W(IW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Per-search schedule: cycle in RUN at which each core reports, its validity, quit cycle.
    int              fin [NC];
    bit              val [NC];
    int              qc;
    logic [NC*RW-1:0] hashes;

    // Results the dispatcher should be holding after the most recent search.
    logic            exp_flag = 1'b0;
    logic [IW-1:0]   exp_wid  = '0;
    logic [RW-1:0]   exp_hash = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_hashes();
        for (int w = 0; w < NC*RW/32; w++) hashes[w*32 +: 32] = $urandom;
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_flag"}, 512'(bus.valid_hash_flag), 512'(exp_flag));
        chk({tag, "_wid"},  512'(bus.winner_id), 512'(exp_wid));
        chk({tag, "_hash"}, 512'(bus.valid_hash), 512'(exp_hash));
    endtask

    task automatic run_search(input logic [NW-1:0] base);
        int             ev;
        int             kind;   // 1 win, 2 exhausted, 3 aborted
        int             wid;
        logic [NC-1:0]  seen;
        logic [NC-1:0]  exp_quit;
        logic [NW-1:0]  e_nonce;

        // Walk the search cycle by cycle using the outcome rules directly.
        ev = -1; kind = 0; wid = 0; exp_quit = '0;
        for (int c = 0; c < 64 && ev < 0; c++) begin
            seen = '0;
            for (int i = 0; i < NC; i++) if (fin[i] <= c) seen[i] = 1'b1;
            wid = -1;
            for (int i = NC - 1; i >= 0; i--) if (fin[i] == c && val[i]) wid = i;
            if (c == qc) begin
                kind = 3; exp_quit = ~seen; ev = c;
            end else if (wid >= 0) begin
                kind = 1; exp_quit = ~seen; ev = c;
            end else if (seen == '1) begin
                kind = 2; ev = c;
            end
        end
        if (ev < 0) begin
            chk("model_no_end", 512'(0), 512'(1));
            return;
        end

        bus.begin_hash = 1'b1;
        bus.nonce_base = base;
        bus.core_hash  = hashes;
        step();
        chk("launch_begin", 512'(bus.core_begin), 512'({NC{1'b1}}));
        chk("launch_busy", 512'(bus.busy), 512'(1));
        chk("launch_flag", 512'(bus.valid_hash_flag), 512'(0));
        chk("launch_stride", 512'(bus.core_nonce_stride), 512'(NC));
        for (int i = 0; i < NC; i++) begin
            e_nonce = base + NW'(i);
            chk("launch_nonce", 512'(bus.core_nonce_start[i*NW +: NW]), 512'(e_nonce));
        end

        // Stale done/valid pulses during LAUNCH must be ignored.
        bus.begin_hash = 1'b0;
        bus.core_done  = NC'($urandom);
        bus.core_valid = '1;
        step();
        chk("run_begin_off", 512'(bus.core_begin), 512'(0));

        for (int c = 0; c <= ev; c++) begin
            for (int i = 0; i < NC; i++) begin
                bus.core_done[i]  = (fin[i] == c);
                bus.core_valid[i] = (fin[i] == c) ? val[i] : 1'($urandom);
            end
            bus.quit_hash  = (c == qc);
            bus.begin_hash = 1'($urandom);
            step();
            if (c < ev) begin
                chk("run_quit", 512'(bus.core_quit), 512'(0));
                chk("run_done", 512'(bus.hash_done), 512'(0));
                chk("run_busy", 512'(bus.busy), 512'(1));
                chk("run_begin", 512'(bus.core_begin), 512'(0));
            end
        end

        bus.begin_hash = 1'b0;
        bus.quit_hash  = 1'($urandom);
        bus.core_done  = NC'($urandom);
        bus.core_valid = '1;

        if (kind == 1) begin
            exp_flag = 1'b1;
            exp_wid  = IW'(wid);
            exp_hash = hashes[wid*RW +: RW];
            chk("win_quit", 512'(bus.core_quit), 512'(exp_quit));
            chk("win_done_early", 512'(bus.hash_done), 512'(0));
            check_held("win");
            step();
            chk("win_done", 512'(bus.hash_done), 512'(1));
            chk("win_quit_off", 512'(bus.core_quit), 512'(0));
            check_held("win_rep");
        end else if (kind == 2) begin
            exp_flag = 1'b0;
            chk("exh_quit", 512'(bus.core_quit), 512'(0));
            chk("exh_done", 512'(bus.hash_done), 512'(1));
            chk("exh_flag", 512'(bus.valid_hash_flag), 512'(0));
        end else begin
            exp_flag = 1'b0;
            chk("abt_quit", 512'(bus.core_quit), 512'(exp_quit));
            chk("abt_done", 512'(bus.hash_done), 512'(0));
            chk("abt_flag", 512'(bus.valid_hash_flag), 512'(0));
        end

        step();
        chk("idle_busy", 512'(bus.busy), 512'(0));
        chk("idle_done", 512'(bus.hash_done), 512'(0));
        chk("idle_quit", 512'(bus.core_quit), 512'(0));
        for (int k = 0; k < 2; k++) begin
            bus.core_done  = NC'($urandom);
            bus.quit_hash  = 1'($urandom);
            step();
            chk("hold_done", 512'(bus.hash_done), 512'(0));
            chk("hold_busy", 512'(bus.busy), 512'(0));
            check_held("hold");
        end
        bus.core_done = '0;
        bus.quit_hash = 1'b0;
    endtask

    task automatic sched(input int f0, f1, f2, f3, input bit v0, v1, v2, v3, input int q);
        fin[0] = f0; fin[1] = f1; fin[2] = f2; fin[3] = f3;
        val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
        qc = q;
    endtask

    initial begin
        logic [NW-1:0] e_nonce;
        logic [NW-1:0] wrap_base;

        bus.begin_hash = 1'b0;
        bus.quit_hash  = 1'b0;
        bus.nonce_base = '0;
        bus.core_done  = '0;
        bus.core_valid = '0;
        bus.core_hash  = '0;
        hashes         = '0;
        step();
        step();
        chk("rst_begin", 512'(bus.core_begin), 512'(0));
        chk("rst_quit", 512'(bus.core_quit), 512'(0));
        chk("rst_done", 512'(bus.hash_done), 512'(0));
        chk("rst_busy", 512'(bus.busy), 512'(0));
        chk("rst_nonce", 512'(bus.core_nonce_start), 512'(0));
        check_held("rst");
        n_rst = 1'b0;
        step();

        rand_hashes();
        sched(NEVER, NEVER, 2, NEVER, 0, 0, 1, 0, -1);
        run_search(32'h0000_1000);
        rand_hashes();
        sched(NEVER, 1, NEVER, 1, 0, 1, 0, 1, -1);
        run_search(32'h1234_5678);
        rand_hashes();
        sched(0, 2, 1, 3, 0, 0, 0, 0, -1);
        run_search(32'h0000_0040);
        rand_hashes();
        sched(0, NEVER, NEVER, NEVER, 1, 0, 0, 0, 0);
        run_search(32'h0000_2000);

        for (int n = 0; n < 150; n++) begin
            rand_hashes();
            for (int i = 0; i < NC; i++) begin
                fin[i] = int'($urandom_range(0, 9));
                val[i] = ($urandom_range(0, 3) == 0);
            end
            qc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_search($urandom);
        end

        // Wrapping nonce split, then reset in the middle of RUN.
        wrap_base      = 32'hFFFF_FFFE;
        bus.begin_hash = 1'b1;
        bus.nonce_base = wrap_base;
        step();
        for (int i = 0; i < NC; i++) begin
            e_nonce = wrap_base + NW'(i);
            chk("wrap_nonce", 512'(bus.core_nonce_start[i*NW +: NW]), 512'(e_nonce));
        end
        bus.begin_hash = 1'b0;
        step();
        bus.begin_hash = 1'b1;
        step();
        chk("run_ignore_begin", 512'(bus.core_begin), 512'(0));
        chk("run_ignore_busy", 512'(bus.busy), 512'(1));
        bus.begin_hash = 1'b0;
        n_rst = 1'b1;
        step();
        exp_flag = 1'b0;
        exp_wid  = '0;
        exp_hash = '0;
        chk("mid_rst_busy", 512'(bus.busy), 512'(0));
        chk("mid_rst_quit", 512'(bus.core_quit), 512'(0));
        chk("mid_rst_done", 512'(bus.hash_done), 512'(0));
        chk("mid_rst_begin", 512'(bus.core_begin), 512'(0));
        chk("mid_rst_nonce", 512'(bus.core_nonce_start), 512'(0));
        check_held("mid_rst");
        n_rst = 1'b0;
        step();
        chk("post_rst_busy", 512'(bus.busy), 512'(0));
        chk("post_rst_done", 512'(bus.hash_done), 512'(0));
        chk("post_rst_quit", 512'(bus.core_quit), 512'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_core_hash_dispatcher.md
Name: multi_core_hash_dispatcher

Overview:
- Parametrised successor to the single hash-module arrangement; sits between main_controller and NUM_CORES parallel hash-module instances.
- Splits one nonce search across the cores by interleaving start nonces, launches them together, and sticky-tracks completion.
- Selects the winning result with a deterministic lowest-index rule, quits every core, and gives the controller the same hash_done / valid_hash_flag / valid_hash view a single core gives.

Parameters:
NUM_CORES, 4, number of hash cores driven (1..16)
NONCE_W, 32, nonce width in bits
RESULT_W, 288, width of one core's valid_hash result
ID_W, 2, winner index width; must equal max(1, clog2(NUM_CORES))

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  synchronous, active-high reset (1 = reset, sampled on clk rising edge)
begin_hash  in  1  start search request from main_controller (level sampled per cycle)
quit_hash  in  1  abort request from main_controller
nonce_base  in  NONCE_W  first nonce of the search, latched at accept
core_begin  out  NUM_CORES  one-cycle start pulse per core
core_quit  out  NUM_CORES  one-cycle quit pulse per core
core_nonce_start  out  NUM_CORES*NONCE_W  per-core start nonce; slice i = bits [i*NONCE_W +: NONCE_W]
core_nonce_stride  out  NONCE_W  constant NUM_CORES, zero-extended
core_done  in  NUM_CORES  per-core done pulse
core_valid  in  NUM_CORES  per-core valid flag; meaningful only when the matching core_done is 1
core_hash  in  NUM_CORES*RESULT_W  per-core result, slice i
hash_done  out  1  one-cycle completion pulse to controller
valid_hash_flag  out  1  1 = last completed search found a valid hash
valid_hash  out  RESULT_W  winning result
winner_id  out  ID_W  index of the winning core
busy  out  1  1 in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; core_begin, core_quit, hash_done, valid_hash_flag = 0; valid_hash, winner_id, core_nonce_start = 0; done_mask = 0; busy = 0.
- Reset mid-search returns to IDLE immediately, with no core_quit and no hash_done.
- States: IDLE, LAUNCH, RUN, QUIT, REPORT, ABORT.
- IDLE:
  - begin_hash=1: latch nonce_base, clear done_mask, clear valid_hash_flag, go to LAUNCH.
  - begin_hash outside IDLE is ignored.
- LAUNCH (1 cycle):
  - core_begin = all ones.
  - core_nonce_start[i] = nonce_base + i, modulo 2^NONCE_W (wraps, e.g. base FFFFFFFE, core 3 gets 00000001).
  - core_nonce_start holds until the next LAUNCH.
  - Go to RUN.
  - Latency: begin_hash accepted at cycle t, core_begin high at t+1.
- RUN:
  - done_mask |= core_done each cycle.
  - Win detection: any i with core_done[i] & core_valid[i]. If several in one cycle, lowest i wins. Latch core_hash slice i into valid_hash, i into winner_id, set valid_hash_flag=1, go to QUIT.
  - Exhaustion: (done_mask | core_done) all ones with no valid in that cycle: valid_hash_flag=0, go to REPORT without QUIT. Cores are already done.
  - quit_hash=1 takes priority over both a win and exhaustion in the same cycle: go to ABORT.
  - A core that finishes invalid is not relaunched.
- QUIT (1 cycle): core_quit = ~done_mask_including_winner, so no quit goes to cores already done. Go to REPORT.
- REPORT (1 cycle): hash_done=1, go to IDLE.
  - Win at cycle t: core_quit at t+1, hash_done at t+2.
  - Exhaustion at cycle t: hash_done at t+1.
- After REPORT, valid_hash_flag, valid_hash and winner_id hold until the next accepted begin_hash.
- ABORT (1 cycle): core_quit = ~done_mask; hash_done stays 0; valid_hash_flag=0. Go to IDLE.
- quit_hash outside RUN is ignored.
- core_done from any core outside RUN is ignored (stale pulses).
- With NUM_CORES=1 the block behaves as the single core did, plus 1 cycle of launch latency and 1–2 cycles of report latency.

Test Plan:
- Reset, then begin_hash with nonce_base=0x00001000, NUM_CORES=4 -> core_begin=4'b1111 one cycle later; slices 0x1000, 0x1001, 0x1002, 0x1003; stride=4; busy=1.
- Core 2 done+valid with core_hash=H2 at cycle t -> core_quit=4'b1011 at t+1; hash_done pulse at t+2; valid_hash=H2, winner_id=2, valid_hash_flag=1; back to IDLE.
- Cores 1 and 3 done+valid in the same cycle -> winner_id=1, valid_hash=H1, core_quit=4'b0101.
- Cores finish invalid one at a time (0, 2, 1, 3) -> no core_quit; hash_done at the cycle after core 3 finishes; valid_hash_flag=0.
- quit_hash in the same cycle as core 0 done+valid -> core_quit=4'b1110, no hash_done, valid_hash_flag=0, IDLE.
- nonce_base=0xFFFFFFFE -> starts FFFFFFFE, FFFFFFFF, 00000000, 00000001. Then assert n_rst during RUN -> all outputs 0 next cycle; begin_hash during RUN is ignored.
